// File: rtl/cpu_pkg.sv
// Shared Mini-SRC definitions: opcodes, sequencer states, ALU op codes and the DataPath control word.
package cpu_pkg;
    localparam int OPW = 5;
    localparam int STW = 4;

    typedef enum logic [STW-1:0] {
        ST_RST  = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_T7   = 4'd8,
        ST_HALT = 4'd9,
        ST_WAIT = 4'd10
    } state_t;

    localparam logic [OPW-1:0] OP_LD   = 5'd0;
    localparam logic [OPW-1:0] OP_LDI  = 5'd1;
    localparam logic [OPW-1:0] OP_ST   = 5'd2;
    localparam logic [OPW-1:0] OP_ADD  = 5'd3;
    localparam logic [OPW-1:0] OP_SUB  = 5'd4;
    localparam logic [OPW-1:0] OP_AND  = 5'd5;
    localparam logic [OPW-1:0] OP_OR   = 5'd6;
    localparam logic [OPW-1:0] OP_ROR  = 5'd7;
    localparam logic [OPW-1:0] OP_ROL  = 5'd8;
    localparam logic [OPW-1:0] OP_SHR  = 5'd9;
    localparam logic [OPW-1:0] OP_SHRA = 5'd10;
    localparam logic [OPW-1:0] OP_SHL  = 5'd11;
    localparam logic [OPW-1:0] OP_ADDI = 5'd12;
    localparam logic [OPW-1:0] OP_ANDI = 5'd13;
    localparam logic [OPW-1:0] OP_ORI  = 5'd14;
    localparam logic [OPW-1:0] OP_MUL  = 5'd15;
    localparam logic [OPW-1:0] OP_DIV  = 5'd16;
    localparam logic [OPW-1:0] OP_NEG  = 5'd17;
    localparam logic [OPW-1:0] OP_NOT  = 5'd18;
    localparam logic [OPW-1:0] OP_BR   = 5'd19;
    localparam logic [OPW-1:0] OP_JR   = 5'd20;
    localparam logic [OPW-1:0] OP_IN   = 5'd22;
    localparam logic [OPW-1:0] OP_OUT  = 5'd23;
    localparam logic [OPW-1:0] OP_MFHI = 5'd24;
    localparam logic [OPW-1:0] OP_MFLO = 5'd25;
    localparam logic [OPW-1:0] OP_NOP  = 5'd26;
    localparam logic [OPW-1:0] OP_HALT = 5'd27;

    // The ALU shares the opcode encoding, so address/PC arithmetic just asks for ADD.
    localparam logic [OPW-1:0] ALU_ADD = OP_ADD;

    typedef struct packed {
        logic           Gra, Grb, Grc, Rin, Rout, BAout;
        logic           PCout, PCin, IncPC, IRin, MARin;
        logic           MDRin, MDRout, Read, Write;
        logic           Yin, Zin, Zhighout, Zlowout, Cout;
        logic           HIin, HIout, LOin, LOout;
        logic           InPortout, OutPortin, CONin;
        logic [OPW-1:0] alu_op;
    } ctrl_t;

    // Final execute state of each instruction; anything not listed finishes in T3.
    function automatic state_t last_step(input logic [OPW-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
            OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: return ST_T5;
            OP_NEG, OP_NOT:                   return ST_T4;
            OP_MUL, OP_DIV, OP_BR:            return ST_T6;
            OP_LD, OP_ST:                     return ST_T7;
            default:                          return ST_T3;
        endcase
    endfunction
endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> DataPath bundle: IR/condition/stop inputs and every DataPath strobe.
interface control_unit_if;
    logic [31:0]                ir;
    logic                       con_ff;
    logic                       stop;
    logic                       run;
    logic                       Gra, Grb, Grc, Rin, Rout, BAout;
    logic                       PCout, PCin, IncPC, IRin, MARin;
    logic                       MDRin, MDRout, Read, Write;
    logic                       Yin, Zin, Zhighout, Zlowout, Cout;
    logic                       HIin, HIout, LOin, LOout;
    logic                       InPortout, OutPortin, CONin;
    logic [cpu_pkg::OPW-1:0]    alu_op;

    modport master (
        input  ir, con_ff, stop,
        output run, Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, IRin, MARin,
               MDRin, MDRout, Read, Write, Yin, Zin, Zhighout, Zlowout, Cout,
               HIin, HIout, LOin, LOout, InPortout, OutPortin, CONin, alu_op
    );

    modport slave (
        output ir, con_ff, stop,
        input  run, Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, IRin, MARin,
               MDRin, MDRout, Read, Write, Yin, Zin, Zhighout, Zlowout, Cout,
               HIin, HIout, LOin, LOout, InPortout, OutPortin, CONin, alu_op
    );
endinterface

// File: rtl/cu_step_decoder.sv
// Combinational decode of (state, opcode, con_ff) into the DataPath control word.
module cu_step_decoder
    import cpu_pkg::*;
(
    input  state_t         state,
    input  logic [OPW-1:0] opcode,
    input  logic           con_ff,
    output ctrl_t          ctrl
);
    logic is_imm;
    assign is_imm = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_T0: begin ctrl.PCout = 1'b1; ctrl.MARin = 1'b1; ctrl.IncPC = 1'b1; ctrl.Zin = 1'b1; end
            ST_T1: begin ctrl.Zlowout = 1'b1; ctrl.PCin = 1'b1; ctrl.Read = 1'b1; ctrl.MDRin = 1'b1; end
            ST_T2: begin ctrl.MDRout = 1'b1; ctrl.IRin = 1'b1; end
            ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
                    OP_ADDI, OP_ANDI, OP_ORI: begin
                        case (state)
                            ST_T3: begin ctrl.Grb = 1'b1; ctrl.Rout = 1'b1; ctrl.Yin = 1'b1; end
                            ST_T4: begin
                                ctrl.Zin    = 1'b1;
                                ctrl.alu_op = opcode;
                                if (is_imm) ctrl.Cout = 1'b1;
                                else begin ctrl.Grc = 1'b1; ctrl.Rout = 1'b1; end
                            end
                            ST_T5: begin ctrl.Zlowout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1; end
                            default: ;
                        endcase
                    end
                    OP_NEG, OP_NOT: begin
                        case (state)
                            ST_T3: begin ctrl.Grb = 1'b1; ctrl.Rout = 1'b1; ctrl.Zin = 1'b1; ctrl.alu_op = opcode; end
                            ST_T4: begin ctrl.Zlowout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1; end
                            default: ;
                        endcase
                    end
                    OP_MUL, OP_DIV: begin
                        case (state)
                            ST_T3: begin ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.Yin = 1'b1; end
                            ST_T4: begin ctrl.Grb = 1'b1; ctrl.Rout = 1'b1; ctrl.Zin = 1'b1; ctrl.alu_op = opcode; end
                            ST_T5: begin ctrl.Zlowout = 1'b1; ctrl.LOin = 1'b1; end
                            ST_T6: begin ctrl.Zhighout = 1'b1; ctrl.HIin = 1'b1; end
                            default: ;
                        endcase
                    end
                    OP_LD, OP_LDI, OP_ST: begin
                        case (state)
                            ST_T3: begin ctrl.Grb = 1'b1; ctrl.BAout = 1'b1; ctrl.Yin = 1'b1; end
                            ST_T4: begin ctrl.Cout = 1'b1; ctrl.Zin = 1'b1; ctrl.alu_op = ALU_ADD; end
                            ST_T5: begin
                                ctrl.Zlowout = 1'b1;
                                if (opcode == OP_LDI) begin ctrl.Gra = 1'b1; ctrl.Rin = 1'b1; end
                                else ctrl.MARin = 1'b1;
                            end
                            // Store loads MDR from the bus: Read stays low so MDR muxes the bus.
                            ST_T6: begin
                                if (opcode == OP_LD) begin ctrl.Read = 1'b1; ctrl.MDRin = 1'b1; end
                                else if (opcode == OP_ST) begin ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.MDRin = 1'b1; end
                            end
                            ST_T7: begin
                                if (opcode == OP_LD) begin ctrl.MDRout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1; end
                                else if (opcode == OP_ST) ctrl.Write = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    OP_BR: begin
                        case (state)
                            ST_T3: begin ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.CONin = 1'b1; end
                            ST_T4: begin ctrl.PCout = 1'b1; ctrl.Yin = 1'b1; end
                            ST_T5: begin ctrl.Cout = 1'b1; ctrl.Zin = 1'b1; ctrl.alu_op = ALU_ADD; end
                            ST_T6: begin ctrl.Zlowout = 1'b1; ctrl.PCin = con_ff; end
                            default: ;
                        endcase
                    end
                    OP_JR:   if (state == ST_T3) begin ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.PCin = 1'b1; end
                    OP_IN:   if (state == ST_T3) begin ctrl.InPortout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1; end
                    OP_OUT:  if (state == ST_T3) begin ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.OutPortin = 1'b1; end
                    OP_MFHI: if (state == ST_T3) begin ctrl.HIout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1; end
                    OP_MFLO: if (state == ST_T3) begin ctrl.LOout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/control_unit.sv
// Hardwired Mini-SRC sequencer: state register, next-state and stop handling.
// Optional CU_SINGLE_STEP_EN adds a step input and a WAIT state between instructions.
module control_unit
    import cpu_pkg::*;
(
    input  logic          clock,
    input  logic          clear,
`ifdef CU_SINGLE_STEP_EN
    input  logic          step,
`endif
    control_unit_if.master bus
);
    // state | meaning
    // RST   | held in clear, all strobes low
    // T0-T2 | instruction fetch
    // T3-T7 | per-opcode execute steps
    // HALT  | stopped, left only through clear
    // WAIT  | single-step pause between instructions

`ifdef CU_SINGLE_STEP_EN
    localparam state_t ST_DONE = ST_WAIT;
`else
    localparam state_t ST_DONE = ST_T0;
`endif

    state_t         state;
    state_t         state_nx;
    logic [OPW-1:0] opcode;
    ctrl_t          ctrl;
    logic           unused_ir;

    assign opcode    = bus.ir[31:27];
    assign unused_ir = ^bus.ir[26:0];

    always_comb begin
        state_nx = state;
        case (state)
            ST_RST:  state_nx = ST_T0;
            ST_T0:   state_nx = ST_T1;
            ST_T1:   state_nx = ST_T2;
            ST_T2:   state_nx = ST_T3;
            ST_HALT: state_nx = ST_HALT;
            ST_WAIT: begin
`ifdef CU_SINGLE_STEP_EN
                state_nx = step ? ST_T0 : ST_WAIT;
`else
                state_nx = ST_T0;
`endif
            end
            default: begin
                if (state == ST_T3 && opcode == OP_HALT) begin
                    state_nx = ST_HALT;
                end else if (state == last_step(opcode)) begin
                    state_nx = bus.stop ? ST_HALT : ST_DONE;
                end else begin
                    case (state)
                        ST_T3:   state_nx = ST_T4;
                        ST_T4:   state_nx = ST_T5;
                        ST_T5:   state_nx = ST_T6;
                        ST_T6:   state_nx = ST_T7;
                        default: state_nx = ST_T0;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) state <= ST_RST;
        else        state <= state_nx;
    end

    cu_step_decoder u_decoder (
        .state  (state),
        .opcode (opcode),
        .con_ff (bus.con_ff),
        .ctrl   (ctrl)
    );

    assign bus.run       = (state != ST_RST) && (state != ST_HALT) && (state != ST_WAIT);
    assign bus.Gra       = ctrl.Gra;
    assign bus.Grb       = ctrl.Grb;
    assign bus.Grc       = ctrl.Grc;
    assign bus.Rin       = ctrl.Rin;
    assign bus.Rout      = ctrl.Rout;
    assign bus.BAout     = ctrl.BAout;
    assign bus.PCout     = ctrl.PCout;
    assign bus.PCin      = ctrl.PCin;
    assign bus.IncPC     = ctrl.IncPC;
    assign bus.IRin      = ctrl.IRin;
    assign bus.MARin     = ctrl.MARin;
    assign bus.MDRin     = ctrl.MDRin;
    assign bus.MDRout    = ctrl.MDRout;
    assign bus.Read      = ctrl.Read;
    assign bus.Write     = ctrl.Write;
    assign bus.Yin       = ctrl.Yin;
    assign bus.Zin       = ctrl.Zin;
    assign bus.Zhighout  = ctrl.Zhighout;
    assign bus.Zlowout   = ctrl.Zlowout;
    assign bus.Cout      = ctrl.Cout;
    assign bus.HIin      = ctrl.HIin;
    assign bus.HIout     = ctrl.HIout;
    assign bus.LOin      = ctrl.LOin;
    assign bus.LOout     = ctrl.LOout;
    assign bus.InPortout = ctrl.InPortout;
    assign bus.OutPortin = ctrl.OutPortin;
    assign bus.CONin     = ctrl.CONin;
    assign bus.alu_op    = ctrl.alu_op;
endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-instruction strobe sequences against a step-list model.
module tb_control_unit;
    logic clock = 1'b0;
    logic clear = 1'b0;
`ifdef CU_SINGLE_STEP_EN
    logic step = 1'b1;
`endif

    control_unit_if bus();

    control_unit dut (
        .clock (clock),
        .clear (clear),
`ifdef CU_SINGLE_STEP_EN
        .step  (step),
`endif
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    logic [32:0] exp_q[$];

    localparam logic [4:0] OP_LD = 5'd0, OP_LDI = 5'd1, OP_ST = 5'd2, OP_ADD = 5'd3, OP_SHL = 5'd11;
    localparam logic [4:0] OP_ADDI = 5'd12, OP_ORI = 5'd14, OP_MUL = 5'd15, OP_DIV = 5'd16;
    localparam logic [4:0] OP_NEG = 5'd17, OP_NOT = 5'd18, OP_BR = 5'd19, OP_JR = 5'd20;
    localparam logic [4:0] OP_IN = 5'd22, OP_OUT = 5'd23, OP_MFHI = 5'd24, OP_MFLO = 5'd25;
    localparam logic [4:0] OP_NOP = 5'd26, OP_HALT = 5'd27;

    localparam logic [32:0] NONE = 33'd0;
    localparam logic [32:0] GRA = 33'd1 << 0,  GRB = 33'd1 << 1,  GRC = 33'd1 << 2,  RIN = 33'd1 << 3;
    localparam logic [32:0] ROUT = 33'd1 << 4, BAOUT = 33'd1 << 5, PCOUT = 33'd1 << 6, PCIN = 33'd1 << 7;
    localparam logic [32:0] INCPC = 33'd1 << 8, IRIN = 33'd1 << 9, MARIN = 33'd1 << 10, MDRIN = 33'd1 << 11;
    localparam logic [32:0] MDROUT = 33'd1 << 12, READ = 33'd1 << 13, WRITE = 33'd1 << 14, YIN = 33'd1 << 15;
    localparam logic [32:0] ZIN = 33'd1 << 16, ZHIGHOUT = 33'd1 << 17, ZLOWOUT = 33'd1 << 18, COUT = 33'd1 << 19;
    localparam logic [32:0] HIIN = 33'd1 << 20, HIOUT = 33'd1 << 21, LOIN = 33'd1 << 22, LOOUT = 33'd1 << 23;
    localparam logic [32:0] INPORTOUT = 33'd1 << 24, OUTPORTIN = 33'd1 << 25, CONIN = 33'd1 << 26;
    localparam logic [32:0] RUN = 33'd1 << 32;
    localparam logic [32:0] DRIVERS = PCOUT | MDROUT | ZHIGHOUT | ZLOWOUT | HIOUT | LOOUT | INPORTOUT | ROUT | BAOUT | COUT;

    function automatic logic [32:0] alu(input logic [4:0] op);
        return {1'b0, op, 27'd0};
    endfunction

    function automatic logic [32:0] observe();
        return {bus.run, bus.alu_op, bus.CONin, bus.OutPortin, bus.InPortout, bus.LOout, bus.LOin,
                bus.HIout, bus.HIin, bus.Cout, bus.Zlowout, bus.Zhighout, bus.Zin, bus.Yin, bus.Write,
                bus.Read, bus.MDRout, bus.MDRin, bus.MARin, bus.IRin, bus.IncPC, bus.PCin, bus.PCout,
                bus.BAout, bus.Rout, bus.Rin, bus.Grc, bus.Grb, bus.Gra};
    endfunction

    // Expected strobe word for every cycle of one instruction, fetch included.
    task automatic build_seq(input logic [4:0] op, input logic c);
        exp_q.delete();
        exp_q.push_back(RUN | PCOUT | MARIN | INCPC | ZIN);
        exp_q.push_back(RUN | ZLOWOUT | PCIN | READ | MDRIN);
        exp_q.push_back(RUN | MDROUT | IRIN);
        if (op inside {[OP_ADD:OP_SHL], [OP_ADDI:OP_ORI]}) begin
            exp_q.push_back(RUN | GRB | ROUT | YIN);
            exp_q.push_back(RUN | ZIN | alu(op) | ((op inside {[OP_ADDI:OP_ORI]}) ? COUT : (GRC | ROUT)));
            exp_q.push_back(RUN | ZLOWOUT | GRA | RIN);
        end else if (op == OP_NEG || op == OP_NOT) begin
            exp_q.push_back(RUN | GRB | ROUT | ZIN | alu(op));
            exp_q.push_back(RUN | ZLOWOUT | GRA | RIN);
        end else if (op == OP_MUL || op == OP_DIV) begin
            exp_q.push_back(RUN | GRA | ROUT | YIN);
            exp_q.push_back(RUN | GRB | ROUT | ZIN | alu(op));
            exp_q.push_back(RUN | ZLOWOUT | LOIN);
            exp_q.push_back(RUN | ZHIGHOUT | HIIN);
        end else if (op == OP_LD || op == OP_LDI || op == OP_ST) begin
            exp_q.push_back(RUN | GRB | BAOUT | YIN);
            exp_q.push_back(RUN | COUT | ZIN | alu(OP_ADD));
            exp_q.push_back(RUN | ZLOWOUT | ((op == OP_LDI) ? (GRA | RIN) : MARIN));
            if (op == OP_LD) begin
                exp_q.push_back(RUN | READ | MDRIN);
                exp_q.push_back(RUN | MDROUT | GRA | RIN);
            end else if (op == OP_ST) begin
                exp_q.push_back(RUN | GRA | ROUT | MDRIN);
                exp_q.push_back(RUN | WRITE);
            end
        end else if (op == OP_BR) begin
            exp_q.push_back(RUN | GRA | ROUT | CONIN);
            exp_q.push_back(RUN | PCOUT | YIN);
            exp_q.push_back(RUN | COUT | ZIN | alu(OP_ADD));
            exp_q.push_back(RUN | ZLOWOUT | (c ? PCIN : NONE));
        end else if (op == OP_JR)   exp_q.push_back(RUN | GRA | ROUT | PCIN);
        else if (op == OP_IN)       exp_q.push_back(RUN | INPORTOUT | GRA | RIN);
        else if (op == OP_OUT)      exp_q.push_back(RUN | GRA | ROUT | OUTPORTIN);
        else if (op == OP_MFHI)     exp_q.push_back(RUN | HIOUT | GRA | RIN);
        else if (op == OP_MFLO)     exp_q.push_back(RUN | LOOUT | GRA | RIN);
        else                        exp_q.push_back(RUN);
    endtask

    // Entered with the DUT about to move into T0 on the next rising edge.
    task automatic run_instr(input string name, input logic [31:0] ir_v, input logic c, input logic s);
        logic [32:0] obs;
        @(posedge clock); #1;
        bus.ir = ir_v; bus.con_ff = c; bus.stop = s;
        build_seq(ir_v[31:27], c);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) @(posedge clock);
            @(negedge clock);
            obs = observe();
            checks++;
            if (obs !== exp_q[i]) begin
                failures++;
                $display("FAIL %s op=%0d T%0d: got %h expected %h", name, ir_v[31:27], i, obs, exp_q[i]);
            end
            checks++;
            if ($countones(obs & DRIVERS) > 1) begin
                failures++;
                $display("FAIL %s bus_drivers T%0d: got %0d drivers expected at most 1", name, i, $countones(obs & DRIVERS));
            end
        end
`ifdef CU_SINGLE_STEP_EN
        if (!s && ir_v[31:27] != OP_HALT) begin
            @(posedge clock); @(negedge clock);
            obs = observe();
            checks++;
            if (obs !== NONE) begin
                failures++;
                $display("FAIL %s wait_state: got %h expected %h", name, obs, NONE);
            end
        end
`endif
    endtask

    task automatic check_idle(input string name, input int cycles);
        logic [32:0] obs;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock); @(negedge clock);
            obs = observe();
            checks++;
            if (obs !== NONE) begin
                failures++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, i, obs, NONE);
            end
        end
    endtask

    // Asserts clear immediately, checks the asynchronous effect, releases at a falling edge.
    task automatic apply_clear(input string name, input int cycles);
        logic [32:0] obs;
        clear = 1'b0;
        #1;
        obs = observe();
        checks++;
        if (obs !== NONE) begin
            failures++;
            $display("FAIL %s async: got %h expected %h", name, obs, NONE);
        end
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            obs = observe();
            checks++;
            if (obs !== NONE) begin
                failures++;
                $display("FAIL %s held cycle %0d: got %h expected %h", name, i, obs, NONE);
            end
        end
        clear = 1'b1;
    endtask

    task automatic test_reset();
        logic [32:0] obs;
        bus.ir = 32'd0; bus.con_ff = 1'b0; bus.stop = 1'b0;
        clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            obs = observe();
            checks++;
            if (obs !== NONE) begin
                failures++;
                $display("FAIL reset cycle %0d: got %h expected %h", i, obs, NONE);
            end
        end
        clear = 1'b1;
    endtask

    task automatic test_add();
        run_instr("add", 32'h18918000, 1'b0, 1'b0);
    endtask

    task automatic test_ld_st();
        run_instr("ld", 32'h00900055, 1'b0, 1'b0);
        run_instr("st", 32'h10900055, 1'b0, 1'b0);
    endtask

    task automatic test_branch();
        run_instr("br_not_taken", {OP_BR, 27'h0880004}, 1'b0, 1'b0);
        run_instr("br_taken", {OP_BR, 27'h0880004}, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [4:0] op;
        for (int n = 0; n < 60; n++) begin
            op = 5'($urandom_range(0, 31));
            if (op == OP_HALT) op = OP_NOP;
            run_instr("random", {op, 27'($urandom)}, 1'($urandom), 1'b0);
        end
    endtask

    task automatic test_stop();
        run_instr("add_stop", 32'h18918000, 1'b0, 1'b1);
        check_idle("halt_after_stop", 20);
        bus.stop = 1'b0;
        apply_clear("clear_from_stop", 2);
    endtask

    task automatic test_halt_opcode();
        run_instr("halt", {OP_HALT, 27'd0}, 1'b0, 1'b0);
        check_idle("halt_idle", 20);
        apply_clear("clear_from_halt", 2);
    endtask

    task automatic test_clear_mid_ld();
        logic [32:0] obs;
        @(posedge clock); #1;
        bus.ir = 32'h00900055; bus.con_ff = 1'b0; bus.stop = 1'b0;
        build_seq(OP_LD, 1'b0);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(posedge clock);
            @(negedge clock);
            obs = observe();
            checks++;
            if (obs !== exp_q[i]) begin
                failures++;
                $display("FAIL ld_partial T%0d: got %h expected %h", i, obs, exp_q[i]);
            end
        end
        #2;
        apply_clear("clear_mid_ld", 1);
        run_instr("restart_add", 32'h18918000, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_add();
        test_ld_st();
        test_branch();
        test_random();
        test_stop();
        test_halt_opcode();
        test_clear_mid_ld();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
